nw_fill_sequencer: RTL and testbench

- Controller that sequences the Needleman-Wunsch score-matrix RAM through two phases: boundary initialisation, then row-major fill of the interior cells.
- The score RAM is single-port, so each interior cell needs three reads (diagonal, up, left), a handshake with the cell-score datapath, and one write.
- Sits between the top-level alignment FSM (start/done) and the score RAM plus the cell-score datapath.

---
 rtl/nw_fill_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_nw_fill_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nw_fill_sequencer.sv
// Needleman-Wunsch score-matrix fill sequencer: writes the boundary row/column, then
// walks the interior cells (read diag/up/left, hand off to the datapath, write back).
module nw_fill_sequencer #(
   parameter int unsigned N   = 4,
   parameter int unsigned AW  = 6,
   parameter int unsigned DW  = 8,
   parameter int unsigned GAP = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        ram_en,
   output logic                        ram_we,
   output logic [AW-1:0]               ram_addr,
   output logic signed [DW-1:0]        init_data,
   output logic                        wr_src,
   output logic                        load_en,
   output logic [1:0]                  load_sel,
   output logic                        calc_start,
   input  logic                        calc_done,
   output logic [$clog2(N+1)-1:0]      idx_i,
   output logic [$clog2(N+1)-1:0]      idx_j
);

   localparam int unsigned IW = $clog2(N + 1);

   localparam logic [AW-1:0]        ROW_STEP = AW'(N + 1);
   localparam logic [AW-1:0]        DIAG_OFF = AW'(N + 2);
   localparam logic [AW-1:0]        ONE_A    = AW'(1);
   localparam logic [IW-1:0]        LAST     = IW'(N);
   localparam logic [IW-1:0]        ONE_I    = IW'(1);
   localparam logic signed [DW-1:0] GAP_S    = DW'(GAP);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_INIT_ROW = 4'd1;
   localparam logic [3:0] S_INIT_COL = 4'd2;
   localparam logic [3:0] S_RD_DIAG  = 4'd3;
   localparam logic [3:0] S_RD_UP    = 4'd4;
   localparam logic [3:0] S_RD_LEFT  = 4'd5;
   localparam logic [3:0] S_LATCH    = 4'd6;
   localparam logic [3:0] S_CALC     = 4'd7;
   localparam logic [3:0] S_WRITE    = 4'd8;
   localparam logic [3:0] S_DONE     = 4'd9;

   logic [3:0]             state_q, state_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [AW-1:0]          rbase_q, rbase_d;
   logic [IW-1:0]          i_d, j_d;
   logic signed [DW-1:0]   init_d;
   logic                   busy_d, done_d, ram_en_d, ram_we_d, wr_src_d;
   logic                   load_en_d, calc_start_d;
   logic [1:0]             load_sel_d;

   // Next state, counters, and the output values that belong to the next state
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rbase_d      = rbase_q;
      i_d          = idx_i;
      j_d          = idx_j;
      init_d       = init_data;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      ram_en_d     = 1'b0;
      ram_we_d     = 1'b0;
      wr_src_d     = 1'b0;
      load_en_d    = 1'b0;
      load_sel_d   = 2'b00;
      calc_start_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_INIT_ROW;
               addr_d  = '0;
               rbase_d = '0;
               i_d     = '0;
               j_d     = '0;
               init_d  = '0;
            end
         end
         S_INIT_ROW: begin
            if (idx_j == LAST) begin
               state_d = S_INIT_COL;
               addr_d  = ROW_STEP;
               rbase_d = ROW_STEP;
               i_d     = ONE_I;
               j_d     = '0;
               init_d  = -GAP_S;
            end else begin
               addr_d  = addr_q + ONE_A;
               j_d     = idx_j + ONE_I;
               init_d  = init_data - GAP_S;
            end
         end
         S_INIT_COL: begin
            if (idx_i == LAST) begin
               state_d = S_RD_DIAG;
               addr_d  = ROW_STEP + ONE_A;
               rbase_d = ROW_STEP;
               i_d     = ONE_I;
               j_d     = ONE_I;
               init_d  = '0;
            end else begin
               addr_d  = addr_q + ROW_STEP;
               i_d     = idx_i + ONE_I;
               init_d  = init_data - GAP_S;
            end
         end
         S_RD_DIAG: state_d = S_RD_UP;
         S_RD_UP:   state_d = S_RD_LEFT;
         S_RD_LEFT: state_d = S_LATCH;
         S_LATCH:   state_d = S_CALC;
         S_CALC: begin
            if (calc_done) state_d = S_WRITE;
         end
         S_WRITE: begin
            // Row wrap uses the row-base register so no i*(N+1) product is needed
            if (idx_j != LAST) begin
               state_d = S_RD_DIAG;
               addr_d  = addr_q + ONE_A;
               j_d     = idx_j + ONE_I;
            end else if (idx_i != LAST) begin
               state_d = S_RD_DIAG;
               rbase_d = rbase_q + ROW_STEP;
               addr_d  = rbase_q + ROW_STEP + ONE_A;
               i_d     = idx_i + ONE_I;
               j_d     = ONE_I;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      unique case (state_d)
         S_INIT_ROW, S_INIT_COL: begin
            busy_d   = 1'b1;
            ram_en_d = 1'b1;
            ram_we_d = 1'b1;
         end
         S_RD_DIAG: begin
            busy_d   = 1'b1;
            ram_en_d = 1'b1;
         end
         S_RD_UP: begin
            busy_d     = 1'b1;
            ram_en_d   = 1'b1;
            load_en_d  = 1'b1;
            load_sel_d = 2'b00;
         end
         S_RD_LEFT: begin
            busy_d     = 1'b1;
            ram_en_d   = 1'b1;
            load_en_d  = 1'b1;
            load_sel_d = 2'b01;
         end
         S_LATCH: begin
            busy_d     = 1'b1;
            load_en_d  = 1'b1;
            load_sel_d = 2'b10;
         end
         S_CALC: begin
            busy_d       = 1'b1;
            calc_start_d = (state_q != S_CALC);
         end
         S_WRITE: begin
            busy_d   = 1'b1;
            ram_en_d = 1'b1;
            ram_we_d = 1'b1;
            wr_src_d = 1'b1;
         end
         S_DONE:  done_d = 1'b1;
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rbase_q    <= '0;
         idx_i      <= '0;
         idx_j      <= '0;
         init_data  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         wr_src     <= 1'b0;
         load_en    <= 1'b0;
         load_sel   <= 2'b00;
         calc_start <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rbase_q    <= rbase_d;
         idx_i      <= i_d;
         idx_j      <= j_d;
         init_data  <= init_d;
         busy       <= busy_d;
         done       <= done_d;
         ram_en     <= ram_en_d;
         ram_we     <= ram_we_d;
         wr_src     <= wr_src_d;
         load_en    <= load_en_d;
         load_sel   <= load_sel_d;
         calc_start <= calc_start_d;
      end
   end

   // Neighbour reads are offsets from the current-cell address counter
   always_comb begin
      unique case (state_q)
         S_RD_DIAG: ram_addr = addr_q - DIAG_OFF;
         S_RD_UP:   ram_addr = addr_q - ROW_STEP;
         S_RD_LEFT: ram_addr = addr_q - ONE_A;
         default:   ram_addr = addr_q;
      endcase
   end

endmodule

// File: tb/tb_nw_fill_sequencer.sv
// Scoreboard bench: expected RAM ops, operand loads and done markers are queued when a fill
// is started; a negedge monitor pops and compares them and checks the handshake timing.
module tb_nw_fill_sequencer;

   localparam int N    = 3;
   localparam int AW   = 4;
   localparam int DW   = 8;
   localparam int GAP  = 2;
   localparam int IW   = $clog2(N + 1);
   localparam int R    = N + 1;
   localparam int BASE = (N + 1) + N + N * N * 6 + 1;

   logic clk, rst, start, calc_done;
   logic busy, done, ram_en, ram_we, wr_src, load_en, calc_start;
   logic [AW-1:0] ram_addr;
   logic signed [DW-1:0] init_data;
   logic [1:0] load_sel;
   logic [IW-1:0] idx_i, idx_j;

   nw_fill_sequencer #(.N(N), .AW(AW), .DW(DW), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .init_data(init_data),
      .wr_src(wr_src), .load_en(load_en), .load_sel(load_sel), .calc_start(calc_start),
      .calc_done(calc_done), .idx_i(idx_i), .idx_j(idx_j)
   );

   // kind: 0 boundary write, 1 read, 2 cell write, 3 done marker
   typedef struct {
      int kind;
      int addr;
      int init;
      int ii;
      int jj;
   } op_t;

   op_t exp_ops[$];
   int  exp_loads[$];
   int  checks = 0;
   int  failures = 0;
   int  done_cnt = 0;
   int  fills_exp = 0;
   bit  calc_mode = 0;
   bit  b2b_mode = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s got=event exp=none", name);
   endtask

   function automatic op_t mk(input int k, input int a, input int v, input int i, input int j);
      op_t o;
      o.kind = k; o.addr = a; o.init = v; o.ii = i; o.jj = j;
      return o;
   endfunction

   // Reference: boundary row, boundary column, then each interior cell in row-major order
   task automatic push_fill();
      for (int j = 0; j <= N; j++) exp_ops.push_back(mk(0, j, -j * GAP, 0, j));
      for (int i = 1; i <= N; i++) exp_ops.push_back(mk(0, i * R, -i * GAP, i, 0));
      for (int i = 1; i <= N; i++) begin
         for (int j = 1; j <= N; j++) begin
            exp_ops.push_back(mk(1, (i - 1) * R + (j - 1), 0, i, j));
            exp_ops.push_back(mk(1, (i - 1) * R + j, 0, i, j));
            exp_ops.push_back(mk(1, i * R + (j - 1), 0, i, j));
            exp_ops.push_back(mk(2, i * R + j, 0, i, j));
            exp_loads.push_back(0);
            exp_loads.push_back(1);
            exp_loads.push_back(2);
         end
      end
      exp_ops.push_back(mk(3, 0, 0, 0, 0));
   endtask

   // Datapath stand-in: immediate completion, or a random level (also outside CALC)
   always @(posedge clk) begin
      #1;
      calc_done = calc_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
   end

   // Monitor
   int  cyc = 0, fill_cycles = 0, calc_cycles = 0, last_done_cyc = 0;
   bit  rst_seen = 0, prev_read = 0, prev_left = 0, prev_calc_cyc = 0, prev_cd = 0;
   bit  in_calc = 0, in_fill = 0, cur_calc = 0, b2b_arm = 0;
   op_t e;
   logic [DW-1:0] gi, ei;

   always @(negedge clk) begin
      cyc++;
      if (rst_seen) begin
         check("reset_outputs",
               64'({busy, done, ram_en, ram_we, ram_addr, init_data, wr_src,
                    load_en, load_sel, calc_start, idx_i, idx_j}), 64'd0);
         prev_read = 0; prev_left = 0; prev_calc_cyc = 0; in_calc = 0; in_fill = 0;
      end else begin
         if (busy && !in_fill) begin
            in_fill = 1; fill_cycles = 0; calc_cycles = 0;
         end
         if (in_fill) fill_cycles++;
         if (prev_calc_cyc) check("calc_exit", 64'(ram_en), 64'(prev_cd));
         if (prev_left || calc_start) check("calc_start", 64'(calc_start), 64'(prev_left));
         if (calc_start) in_calc = 1;
         cur_calc = in_calc && !ram_en;
         if (in_calc && ram_en) in_calc = 0;
         if (cur_calc) calc_cycles++;
         if (prev_read || load_en) check("load_timing", 64'(load_en), 64'(prev_read));
         if (load_en) begin
            if (exp_loads.size() == 0) fail_now("load_unexpected");
            else check("load_sel", 64'(load_sel), 64'(exp_loads.pop_front()));
            if (load_sel == 2'b10) check("latch_no_ram", 64'(ram_en), 64'd0);
         end
         if (ram_en) begin
            if (exp_ops.size() == 0 || exp_ops[0].kind == 3) fail_now("ram_unexpected");
            else begin
               e  = exp_ops.pop_front();
               gi = (e.kind == 0) ? init_data : '0;
               ei = (e.kind == 0) ? DW'(e.init) : '0;
               check("ram_op",
                     64'({busy, ram_we, wr_src, ram_addr, idx_i, idx_j, gi}),
                     64'({1'b1, e.kind != 1, e.kind == 2, AW'(e.addr), IW'(e.ii), IW'(e.jj), ei}));
               if (b2b_arm && e.kind == 0 && e.jj == 0) begin
                  check("restart_gap", 64'(cyc - last_done_cyc), 64'd2);
                  b2b_arm = 0;
               end
            end
         end
         if (done) begin
            if (exp_ops.size() == 0) fail_now("done_unexpected");
            else begin
               e = exp_ops.pop_front();
               check("done_marker", 64'(e.kind), 64'd3);
            end
            check("done_busy", 64'(busy), 64'd0);
            check("fill_cycles", 64'(fill_cycles), 64'(BASE + calc_cycles - N * N));
            in_fill = 0;
            done_cnt++;
            last_done_cyc = cyc;
            if (b2b_mode) b2b_arm = 1;
         end
         prev_read     = ram_en && !ram_we;
         prev_left     = load_en && (load_sel == 2'b10);
         prev_calc_cyc = cur_calc;
         prev_cd       = calc_done;
      end
      rst_seen = rst;
      if (rst) begin
         exp_ops.delete();
         exp_loads.delete();
      end
   end

   task automatic wait_done(input int tgt, input bit noise);
      int c = 0;
      while (done_cnt < tgt && c < 4000) begin
         if (noise) start = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         c++;
      end
      start = 1'b0;
      if (done_cnt < tgt) fail_now("done_timeout");
   endtask

   task automatic do_fill(input bit noise);
      int tgt;
      tgt = done_cnt + 1;
      start = 1'b1;
      push_fill();
      fills_exp++;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(tgt, noise);
   endtask

   initial begin
      int tgt;
      rst = 1'b1;
      start = 1'b1;
      calc_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // immediate calc_done
      calc_mode = 0;
      do_fill(0);

      // abort during RD_UP of cell (1,2), with start coincident with rst
      start = 1'b1;
      push_fill();
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat ((2 * N + 1) + 6 + 1) @(posedge clk);
      #1;
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_fill(0);

      // random datapath latency, then stray start pulses while busy
      calc_mode = 1;
      repeat (3) do_fill(0);
      do_fill(1);

      // start held high across two consecutive fills
      b2b_mode = 1;
      tgt = done_cnt + 2;
      start = 1'b1;
      push_fill();
      push_fill();
      fills_exp += 2;
      wait_done(tgt, 0);
      b2b_mode = 0;

      // idle with start low: no RAM traffic expected
      repeat (20) @(posedge clk);
      #1;
      check("fills_done", 64'(done_cnt), 64'(fills_exp));
      check("queue_empty", 64'(exp_ops.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
